rob_queue_8: RTL and testbench
==============================

Name: rob_queue_8

Overview:
- 8-entry reorder-buffer storage with circular head/tail pointers.
- Stage directly upstream of the 8:1 ROB read mux.
- Holds the eight 168-bit ROB items and drives them out on rob_0..rob_7, together with the head index that the mux uses as its select.
- Entries are allocated in order at dispatch, marked complete out of order at writeback, and retired in order at commit.

Parameters:
- ITEM_W, 168, width of one ROB item (matches ROB_ITEM_INDEX+1).
- DEPTH, 8, number of entries; fixed power of two; pointer width 3.
- RES_W, 32, width of the result field, occupying item bits [RES_W-1:0].

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  discard all entries (mispredict/exception).
- alloc_valid  in  1  dispatch requests one entry.
- alloc_item  in  ITEM_W  item to store; bits [RES_W-1:0] are ignored and written as zero.
- alloc_ready  out  1  an entry can be accepted this cycle.
- alloc_tag  out  3  index the accepted item receives (current tail).
- wb_valid  in  1  writeback of a result.
- wb_tag  in  3  target entry index.
- wb_result  in  RES_W  value written into the target entry's result field.
- commit_valid  out  1  head entry is valid and done.
- commit_ready  in  1  consumer retires the head this cycle.
- head_addr  out  3  head index; drives the select of the 8:1 read mux.
- rob_0 .. rob_7  out  ITEM_W each  registered entry contents.
- count  out  4  number of occupied entries, 0..8.
- full  out  1  count==8.
- empty  out  1  count==0.

Behaviour:
- Per-entry state: valid bit, done bit, ITEM_W data register.
- Reset (async, rst=1):
  - head=tail=0, count=0; all valid and done bits cleared; all data registers cleared to 0.
  - Outputs: rob_*=0, alloc_ready=1, commit_valid=0, head_addr=0, full=0, empty=1, alloc_tag=0.
- Allocation:
  - Fires on alloc_valid && alloc_ready.
  - Writes the item to entry[tail] with the result field zeroed; sets valid=1, done=0; tail increments mod 8.
  - alloc_tag=tail is combinational and valid in the same cycle.
  - Without the optional feature, alloc_ready = !full.
- Writeback:
  - Fires on wb_valid with entry[wb_tag].valid=1: sets done=1 and writes wb_result into bits [RES_W-1:0].
  - Writeback to an invalid entry is ignored and changes no state.
  - A second writeback to an already-done entry overwrites the result.
- Commit:
  - commit_valid = entry[head].valid && entry[head].done, decoded from registered state.
  - A writeback in cycle N makes commit_valid visible no earlier than cycle N+1.
  - Commit fires on commit_valid && commit_ready: clears valid and done of entry[head]; data is retained; head increments mod 8.
  - Commit has no effect when commit_valid=0.
- count update: +1 on allocation only, -1 on commit only, unchanged when both or neither fire in the same cycle.
- Wrap-around: pointers roll over 7->0. full and empty are derived from count, never from pointer equality.
- Same-cycle events:
  - Allocation to tail and commit of head touch different entries, because an allocation while full is impossible unless the feature is enabled.
  - Writeback to the entry being committed in the same cycle is ignored (that entry has already committed).
- flush:
  - Synchronous; highest priority.
  - Next cycle: head=tail=0, count=0, all valid/done bits cleared.
  - Data is retained.
  - Allocation, writeback and commit in the flush cycle are discarded.
- rob_0..rob_7 reflect data registers only and are updated one cycle after the write.

Optional Feature:
- Macro: ROB_FULL_BYPASS_EN.
- Defined:
  - alloc_ready = !full || (commit_valid && commit_ready).
  - When full, allocation and commit may fire in the same cycle. tail equals head in that case; the commit clear is applied first, then the allocation writes the entry with valid=1, done=0. count stays 8.
- Undefined: alloc_ready = !full, and no combinational path runs from commit_ready to alloc_ready.

Decomposition:
- Shared package (rob_pkg), used by this block and the 8:1 mux:
  - ROB_ITEM_W=168, ROB_DEPTH=8, ROB_PTR_W=3, ROB_RES_W=32.
  - Typedef rob_item_t [167:0].
  - Localparams for the result-field bounds.
- One natural sub-module: rob_entry (valid, done and data register, with alloc/wb/commit/flush enables), instantiated 8 times.
- Pointer and count logic stays in the top module.

Test Plan:
- Reset then idle: rst pulse with no inputs -> empty=1, count=0, alloc_ready=1, commit_valid=0, head_addr=0, rob_0..7=0.
- Fill and full: 8 allocations with items 0xA0..0xA7 in bits [167:160] -> alloc_tag runs 0..7, full=1, alloc_ready=0 (feature off), a 9th alloc_valid is not accepted.
- Out-of-order writeback, in-order commit:
  - Allocate 3 entries; writeback tag 2 (0x22), then tag 0 (0x11), with commit_ready=1 throughout.
  - Expected: commit_valid rises the cycle after the tag-0 writeback; head_addr goes 0->1; commit stalls at 1 until tag 1 is written with 0x33, then commits 1 and 2 on consecutive cycles; rob_2[31:0]=0x22.
- Wrap-around: allocate/commit 10 entries one at a time -> tail and head wrap 7->0, count never exceeds 1, alloc_tag of the 9th allocation is 0.
- Flush mid-operation: 5 entries valid, assert flush together with alloc_valid and wb_valid -> next cycle count=0, empty=1, head_addr=0, commit_valid=0, no new entry allocated.
- Bypass (ROB_FULL_BYPASS_EN): full with head done, alloc_valid=1 and commit_ready=1 -> alloc_ready=1, both fire, count stays 8, the old head slot holds the new item with done=0.

Source files
------------

// File: rtl/rob_queue_8_pkg.sv
// Shared ROB definitions: item geometry, pointer/count widths, result-field bounds.
package rob_queue_8_pkg;

  localparam int unsigned ROB_ITEM_W  = 168;
  localparam int unsigned ROB_DEPTH   = 8;
  localparam int unsigned ROB_PTR_W   = 3;
  localparam int unsigned ROB_CNT_W   = 4;
  localparam int unsigned ROB_RES_W   = 32;
  localparam int unsigned ROB_RES_LSB = 0;
  localparam int unsigned ROB_RES_MSB = ROB_RES_W - 1;

  typedef logic [ROB_ITEM_W-1:0] rob_item_t;
  typedef logic [ROB_PTR_W-1:0]  rob_ptr_t;
  typedef logic [ROB_CNT_W-1:0]  rob_cnt_t;
  typedef logic [ROB_RES_W-1:0]  rob_res_t;

  // Keeps the non-result bits of an item; the result field is forced to zero on allocation.
  localparam rob_item_t ROB_KEEP_MASK = {{(ROB_ITEM_W-ROB_RES_W){1'b1}}, {ROB_RES_W{1'b0}}};

endpackage

// File: rtl/rob_queue_8_if.sv
// Dispatch / writeback / commit bus of the ROB storage, plus the entry snapshot outputs.
interface rob_queue_8_if;
  import rob_queue_8_pkg::*;

  logic      flush;
  logic      alloc_valid;
  rob_item_t alloc_item;
  logic      alloc_ready;
  rob_ptr_t  alloc_tag;
  logic      wb_valid;
  rob_ptr_t  wb_tag;
  rob_res_t  wb_result;
  logic      commit_valid;
  logic      commit_ready;
  rob_ptr_t  head_addr;
  rob_item_t rob_0, rob_1, rob_2, rob_3, rob_4, rob_5, rob_6, rob_7;
  rob_cnt_t  count;
  logic      full;
  logic      empty;

  modport master (
    output flush, alloc_valid, alloc_item, wb_valid, wb_tag, wb_result, commit_ready,
    input  alloc_ready, alloc_tag, commit_valid, head_addr, count, full, empty,
    input  rob_0, rob_1, rob_2, rob_3, rob_4, rob_5, rob_6, rob_7
  );

  modport slave (
    input  flush, alloc_valid, alloc_item, wb_valid, wb_tag, wb_result, commit_ready,
    output alloc_ready, alloc_tag, commit_valid, head_addr, count, full, empty,
    output rob_0, rob_1, rob_2, rob_3, rob_4, rob_5, rob_6, rob_7
  );

endinterface

// File: rtl/rob_queue_8_entry.sv
// One ROB slot: valid/done flags and the item register with alloc/wb/commit/flush enables.
module rob_queue_8_entry
  import rob_queue_8_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      flush,
  input  logic      alloc_en,
  input  rob_item_t alloc_data,
  input  logic      wb_en,
  input  rob_res_t  wb_result,
  input  logic      commit_en,
  output logic      valid,
  output logic      done,
  output rob_item_t data
);

  // Flags obey flush first; commit clear precedes allocation so a full-queue bypass reuses the slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      done  <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      done  <= 1'b0;
    end else begin
      if (commit_en) begin
        valid <= 1'b0;
        done  <= 1'b0;
      end
      if (alloc_en) begin
        valid <= 1'b1;
        done  <= 1'b0;
        data  <= alloc_data;
      end
      if (wb_en) begin
        done <= 1'b1;
        data[ROB_RES_MSB:ROB_RES_LSB] <= wb_result;
      end
    end
  end

endmodule

// File: rtl/rob_queue_8.sv
// 8-entry reorder-buffer storage feeding the 8:1 ROB read mux (head_addr is the mux select).
// Optional macro ROB_FULL_BYPASS_EN: allow allocate-while-full when the head commits the same cycle.
module rob_queue_8
  import rob_queue_8_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  rob_queue_8_if.slave bus
);

  rob_ptr_t  head_q, tail_q;
  rob_cnt_t  count_q, count_nxt;
  logic      full_q, empty_q;
  logic      alloc_fire, commit_fire;
  logic      valid_q [ROB_DEPTH];
  logic      done_q  [ROB_DEPTH];
  rob_item_t data_q  [ROB_DEPTH];
  logic      alloc_en  [ROB_DEPTH];
  logic      commit_en [ROB_DEPTH];
  logic      wb_en     [ROB_DEPTH];

  assign bus.commit_valid = valid_q[head_q] && done_q[head_q];

`ifdef ROB_FULL_BYPASS_EN
  assign bus.alloc_ready = !full_q || (bus.commit_valid && bus.commit_ready);
`else
  assign bus.alloc_ready = !full_q;
`endif

  assign alloc_fire  = bus.alloc_valid && bus.alloc_ready && !bus.flush;
  assign commit_fire = bus.commit_valid && bus.commit_ready && !bus.flush;

  assign bus.alloc_tag = tail_q;
  assign bus.head_addr = head_q;
  assign bus.count     = count_q;
  assign bus.full      = full_q;
  assign bus.empty     = empty_q;

  // Occupancy moves only when exactly one of allocate/commit fires.
  always_comb begin
    count_nxt = count_q;
    if (alloc_fire && !commit_fire)      count_nxt = count_q + ROB_CNT_W'(1);
    else if (!alloc_fire && commit_fire) count_nxt = count_q - ROB_CNT_W'(1);
  end

  // Head/tail pointers and registered occupancy flags; flush rewinds everything to slot 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else if (bus.flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      if (alloc_fire)  tail_q <= tail_q + ROB_PTR_W'(1);
      if (commit_fire) head_q <= head_q + ROB_PTR_W'(1);
      count_q <= count_nxt;
      full_q  <= (count_nxt == ROB_CNT_W'(ROB_DEPTH));
      empty_q <= (count_nxt == ROB_CNT_W'(0));
    end
  end

  // Per-slot enables and storage; a writeback racing the commit of its own slot is dropped.
  for (genvar i = 0; i < ROB_DEPTH; i++) begin : g_entry
    assign alloc_en[i]  = alloc_fire && (tail_q == ROB_PTR_W'(i));
    assign commit_en[i] = commit_fire && (head_q == ROB_PTR_W'(i));
    assign wb_en[i]     = bus.wb_valid && !bus.flush && (bus.wb_tag == ROB_PTR_W'(i))
                          && valid_q[i] && !commit_en[i];

    rob_queue_8_entry u_entry (
      .clk        (clk),
      .rst        (rst),
      .flush      (bus.flush),
      .alloc_en   (alloc_en[i]),
      .alloc_data (bus.alloc_item & ROB_KEEP_MASK),
      .wb_en      (wb_en[i]),
      .wb_result  (bus.wb_result),
      .commit_en  (commit_en[i]),
      .valid      (valid_q[i]),
      .done       (done_q[i]),
      .data       (data_q[i])
    );
  end

  assign bus.rob_0 = data_q[0];
  assign bus.rob_1 = data_q[1];
  assign bus.rob_2 = data_q[2];
  assign bus.rob_3 = data_q[3];
  assign bus.rob_4 = data_q[4];
  assign bus.rob_5 = data_q[5];
  assign bus.rob_6 = data_q[6];
  assign bus.rob_7 = data_q[7];

endmodule

// File: tb/tb_rob_queue_8.sv
// Directed bench for rob_queue_8 with a commit scoreboard checked by an independent monitor.
module tb_rob_queue_8;
  import rob_queue_8_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rob_queue_8_if bus ();

  rob_queue_8 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [127:0] MID = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;

  int        checks = 0;
  int        errors = 0;
  rob_item_t exp_item [ROB_DEPTH];
  rob_ptr_t  sbq [$];

  task automatic chk(input string name, input logic [167:0] act, input logic [167:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic rob_item_t rob_at(input rob_ptr_t i);
    case (i)
      3'd0: return bus.rob_0;
      3'd1: return bus.rob_1;
      3'd2: return bus.rob_2;
      3'd3: return bus.rob_3;
      3'd4: return bus.rob_4;
      3'd5: return bus.rob_5;
      3'd6: return bus.rob_6;
      default: return bus.rob_7;
    endcase
  endfunction

  // Commit monitor: every retirement must match the oldest expected slot and its content.
  always @(negedge clk) begin
    if (!rst && bus.commit_valid && bus.commit_ready && !bus.flush) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_commit: got head %0d expected no commit", bus.head_addr);
      end else begin
        rob_ptr_t t;
        t = sbq.pop_front();
        chk("commit_head", 168'(bus.head_addr), 168'(t));
        chk("commit_data", rob_at(t), exp_item[t]);
      end
    end
  end

  task automatic to_drv();
    @(posedge clk);
    #1;
  endtask

  task automatic do_alloc(input logic [7:0] hi, input rob_ptr_t tag);
    bus.alloc_valid = 1'b1;
    bus.alloc_item  = {hi, MID, 32'hDEAD_BEEF};
    @(negedge clk);
    chk("alloc_ready", 168'(bus.alloc_ready), 168'(1));
    chk("alloc_tag", 168'(bus.alloc_tag), 168'(tag));
    to_drv();
    bus.alloc_valid = 1'b0;
    exp_item[tag] = {hi, MID, 32'h0};
    sbq.push_back(tag);
  endtask

  task automatic do_wb(input rob_ptr_t tag, input logic [31:0] res);
    bus.wb_valid  = 1'b1;
    bus.wb_tag    = tag;
    bus.wb_result = res;
    to_drv();
    bus.wb_valid = 1'b0;
    exp_item[tag][31:0] = res;
  endtask

  task automatic do_flush();
    bus.flush = 1'b1;
    sbq.delete();
    to_drv();
    bus.flush = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    bus.flush = 1'b0; bus.alloc_valid = 1'b0; bus.alloc_item = '0;
    bus.wb_valid = 1'b0; bus.wb_tag = '0; bus.wb_result = '0; bus.commit_ready = 1'b0;
    for (int i = 0; i < ROB_DEPTH; i++) exp_item[i] = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Reset then idle
    @(negedge clk);
    chk("rst_empty", 168'(bus.empty), 168'(1));
    chk("rst_full", 168'(bus.full), 168'(0));
    chk("rst_count", 168'(bus.count), 168'(0));
    chk("rst_alloc_ready", 168'(bus.alloc_ready), 168'(1));
    chk("rst_commit_valid", 168'(bus.commit_valid), 168'(0));
    chk("rst_head", 168'(bus.head_addr), 168'(0));
    chk("rst_alloc_tag", 168'(bus.alloc_tag), 168'(0));
    for (int i = 0; i < 8; i++) chk("rst_rob", rob_at(3'(i)), 168'(0));
    to_drv();

    // Fill to full; ninth request refused
    for (int k = 0; k < 8; k++) do_alloc(8'(8'hA0 + k), 3'(k));
    bus.alloc_valid = 1'b1;
    bus.alloc_item  = {8'hEE, MID, 32'h1};
    @(negedge clk);
    chk("full_flag", 168'(bus.full), 168'(1));
    chk("full_count", 168'(bus.count), 168'(8));
    chk("full_alloc_ready", 168'(bus.alloc_ready), 168'(0));
    chk("full_alloc_tag", 168'(bus.alloc_tag), 168'(0));
    to_drv();
    bus.alloc_valid = 1'b0;
    @(negedge clk);
    chk("full_count_hold", 168'(bus.count), 168'(8));
    chk("fill_rob3", bus.rob_3, {8'hA3, MID, 32'h0});
    chk("fill_rob0_untouched", bus.rob_0, {8'hA0, MID, 32'h0});
    to_drv();

    // Drain through writeback + commit
    bus.commit_ready = 1'b1;
    for (int k = 0; k < 8; k++) do_wb(3'(k), 32'h100 + k);
    for (int n = 0; n < 20 && !bus.empty; n++) to_drv();
    @(negedge clk);
    chk("drain_empty", 168'(bus.empty), 168'(1));
    chk("drain_head", 168'(bus.head_addr), 168'(0));
    chk("drain_sb", 168'(sbq.size()), 168'(0));
    to_drv();

    // Out-of-order writeback, in-order commit
    for (int k = 0; k < 3; k++) do_alloc(8'(8'hB0 + k), 3'(k));
    bus.wb_valid = 1'b1; bus.wb_tag = 3'd2; bus.wb_result = 32'h22;
    @(negedge clk);
    chk("ooo_cv_a", 168'(bus.commit_valid), 168'(0));
    to_drv(); exp_item[2][31:0] = 32'h22;
    bus.wb_tag = 3'd0; bus.wb_result = 32'h11;
    @(negedge clk);
    chk("ooo_cv_b", 168'(bus.commit_valid), 168'(0));
    to_drv(); exp_item[0][31:0] = 32'h11;
    bus.wb_valid = 1'b0;
    @(negedge clk);
    chk("ooo_cv_c", 168'(bus.commit_valid), 168'(1));
    chk("ooo_head_c", 168'(bus.head_addr), 168'(0));
    to_drv();
    @(negedge clk);
    chk("ooo_cv_stall", 168'(bus.commit_valid), 168'(0));
    chk("ooo_head_stall", 168'(bus.head_addr), 168'(1));
    to_drv();
    bus.wb_valid = 1'b1; bus.wb_tag = 3'd1; bus.wb_result = 32'h33;
    @(negedge clk);
    chk("ooo_cv_e", 168'(bus.commit_valid), 168'(0));
    to_drv(); exp_item[1][31:0] = 32'h33;
    bus.wb_valid = 1'b0;
    @(negedge clk);
    chk("ooo_cv_f", 168'(bus.commit_valid), 168'(1));
    chk("ooo_head_f", 168'(bus.head_addr), 168'(1));
    to_drv();
    @(negedge clk);
    chk("ooo_cv_g", 168'(bus.commit_valid), 168'(1));
    chk("ooo_head_g", 168'(bus.head_addr), 168'(2));
    chk("ooo_rob2_res", 168'(bus.rob_2[31:0]), 168'(32'h22));
    to_drv();
    @(negedge clk);
    chk("ooo_head_h", 168'(bus.head_addr), 168'(3));
    chk("ooo_empty_h", 168'(bus.empty), 168'(1));
    to_drv();

    // Flush on an empty queue rewinds pointers, then wrap-around one entry at a time
    do_flush();
    for (int k = 0; k < 10; k++) begin
      do_alloc(8'(8'h50 + k), 3'(k));
      @(negedge clk);
      chk("wrap_count", 168'(bus.count), 168'(1));
      to_drv();
      do_wb(3'(k), 32'h500 + k);
      to_drv();
    end
    @(negedge clk);
    chk("wrap_empty", 168'(bus.empty), 168'(1));
    chk("wrap_head", 168'(bus.head_addr), 168'(2));
    chk("wrap_tail", 168'(bus.alloc_tag), 168'(2));
    to_drv();

    // Flush mid-operation with a concurrent alloc and writeback
    bus.commit_ready = 1'b0;
    for (int k = 0; k < 5; k++) do_alloc(8'(8'h60 + k), 3'(2 + k));
    bus.alloc_valid = 1'b1; bus.alloc_item = {8'hEE, MID, 32'h0};
    bus.wb_valid = 1'b1; bus.wb_tag = 3'd2; bus.wb_result = 32'h77;
    bus.commit_ready = 1'b1;
    @(negedge clk);
    chk("pre_flush_count", 168'(bus.count), 168'(5));
    bus.flush = 1'b1;
    sbq.delete();
    to_drv();
    bus.flush = 1'b0; bus.alloc_valid = 1'b0; bus.wb_valid = 1'b0;
    @(negedge clk);
    chk("flush_count", 168'(bus.count), 168'(0));
    chk("flush_empty", 168'(bus.empty), 168'(1));
    chk("flush_head", 168'(bus.head_addr), 168'(0));
    chk("flush_tag", 168'(bus.alloc_tag), 168'(0));
    chk("flush_cv", 168'(bus.commit_valid), 168'(0));
    chk("flush_no_alloc_rob7", bus.rob_7, {8'h57, MID, 32'h507});
    chk("flush_no_wb_rob2", bus.rob_2, {8'h60, MID, 32'h0});
    to_drv();
    to_drv();
    @(negedge clk);
    chk("flush_cv_later", 168'(bus.commit_valid), 168'(0));
    to_drv();

`ifdef ROB_FULL_BYPASS_EN
    // Full queue, head done: allocate and commit in the same cycle
    bus.commit_ready = 1'b0;
    for (int k = 0; k < 8; k++) do_alloc(8'(8'hD0 + k), 3'(k));
    do_wb(3'd0, 32'h9999);
    bus.alloc_valid = 1'b1; bus.alloc_item = {8'hC0, MID, 32'h5};
    bus.commit_ready = 1'b1;
    @(negedge clk);
    chk("byp_alloc_ready", 168'(bus.alloc_ready), 168'(1));
    chk("byp_cv", 168'(bus.commit_valid), 168'(1));
    chk("byp_tag", 168'(bus.alloc_tag), 168'(0));
    to_drv();
    bus.alloc_valid = 1'b0; bus.commit_ready = 1'b0;
    exp_item[0] = {8'hC0, MID, 32'h0};
    sbq.push_back(3'd0);
    @(negedge clk);
    chk("byp_count", 168'(bus.count), 168'(8));
    chk("byp_full", 168'(bus.full), 168'(1));
    chk("byp_head", 168'(bus.head_addr), 168'(1));
    chk("byp_rob0", bus.rob_0, {8'hC0, MID, 32'h0});
    to_drv();
    do_flush();
`endif

    @(negedge clk);
    chk("final_sb_empty", 168'(sbq.size()), 168'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
